fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RISC-V core, directly upstream of decode.
- Owns the program counter and drives the instruction-memory interface.
- Registers fetched instructions into the IF/ID pipeline register, with stall, redirect, memory-wait and misaligned-target handling.
- Decode consumes the IF/ID outputs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when no valid instruction.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- IMEM_addr_o  output  32  instruction fetch address; equals the current PC (pc_q).
- IMEM_data_i  input  32  instruction word; combinational response to IMEM_addr_o, sampled at the clock edge.
- IMEM_ready_i  input  1  1 = IMEM_data_i is valid this cycle; 0 = wait state.
- stall_i  input  1  hazard unit hold request; freezes PC and IF/ID.
- redirect_i  input  1  taken branch, jump or trap from EX.
- redirect_pc_i  input  32  redirect target.
- if_id_valid_o  output  1  IF/ID holds a real instruction.
- if_id_pc_o  output  32  PC of the IF/ID instruction.
- if_id_pc4_o  output  32  if_id_pc_o + 4.
- if_id_instr_o  output  32  instruction word, or NOP_INSTR when not valid.
- if_id_misalign_o  output  1  instruction-address-misaligned exception marker.

Behaviour:
- State:
  - pc_q (32b).
  - misalign_pend (1b).
  - IF/ID register: valid, pc, pc4, instr, misalign.
- Reset, when reset=1 at an edge:
  - pc_q=RESET_PC, misalign_pend=0.
  - if_id_valid_o=0, if_id_pc_o=0, if_id_pc4_o=0, if_id_instr_o=NOP_INSTR, if_id_misalign_o=0.
  - Reset overrides all other inputs, including mid-stall and mid-wait.
- IMEM_addr_o is always pc_q, combinationally. Low 2 bits are always 0.
- Per-edge priority (first match wins):
  1. reset.
  2. redirect_i=1:
     - pc_q={redirect_pc_i[31:2],2'b00}.
     - misalign_pend=|redirect_pc_i[1:0].
     - IF/ID becomes a bubble (valid=0, instr=NOP_INSTR, misalign=0; pc/pc4 don't-care, hold).
     - Overrides stall_i and IMEM_ready_i.
  3. stall_i=1: pc_q, misalign_pend and IF/ID all hold.
  4. misalign_pend=1:
     - IF/ID <= valid=1, pc=pc_q, pc4=pc_q+4, instr=NOP_INSTR, misalign=1.
     - misalign_pend=0; pc_q holds.
     - IMEM is ignored regardless of ready.
  5. IMEM_ready_i=0: IF/ID becomes a bubble; pc_q holds; the same address is refetched.
  6. Normal fetch:
     - IF/ID <= valid=1, pc=pc_q, pc4=pc_q+4, instr=IMEM_data_i, misalign=0.
     - pc_q=pc_q+4.
- Latency: an instruction at address A appears on IF/ID outputs 1 cycle after the edge at which A was presented with ready=1.
- Redirect penalty: the redirect edge produces a bubble; the target instruction appears on IF/ID one edge later (if ready and no stall).
- Arithmetic: pc_q+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Stall + wait: stall wins, IF/ID holds its valid instruction. The memory request is re-issued after the stall releases.
- The stage does not squash instructions already beyond IF/ID; the upstream control issuing redirect_i owns that.
- No combinational path from stall_i or redirect_i to IMEM_addr_o; the effect is visible the cycle after the edge.

Test Plan:
- Reset and straight-line fetch: reset 2 cycles, IMEM returns 32'h00500093 at 0x0 and 32'h00A00113 at 0x4, ready=1.
  -> Cycle after reset release: IMEM_addr_o=0x0, valid=0.
  -> Next edge: instr=0x00500093, pc=0x0, pc4=0x4.
  -> Following edge: instr=0x00A00113, pc=0x4.
- Stall hold: stall_i=1 for 3 cycles while IF/ID holds pc=0x8.
  -> IF/ID and IMEM_addr_o=0xC unchanged for all 3 cycles.
  -> First edge after release: IF/ID pc=0xC.
- Redirect with stall: redirect_i=1, redirect_pc_i=0x100, stall_i=1 on the same edge.
  -> IMEM_addr_o=0x100, IF/ID valid=0, instr=0x00000013.
  -> Next edge: IF/ID pc=0x100, valid=1.
- Memory wait: IMEM_ready_i=0 for 2 cycles at pc=0x20.
  -> Two bubbles (valid=0), IMEM_addr_o stays 0x20.
  -> Ready edge: instr from 0x20, then pc_q=0x24.
- Misaligned redirect: redirect_pc_i=0x202.
  -> IMEM_addr_o=0x200.
  -> Next edge: valid=1, misalign=1, instr=0x00000013, pc=0x200.
  -> Following edge: normal fetch of 0x200, misalign=0.
- Wrap and mid-operation reset: redirect to 0xFFFFFFFC, fetch it.
  -> pc_q=0x0, if_id_pc4_o=0x0.
  -> Assert reset during a wait state: all outputs take reset values at the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// fills the IF/ID pipeline register with stall, redirect, wait and misalign handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IMEM_addr_o,
    input  logic [31:0] IMEM_data_i,
    input  logic        IMEM_ready_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_misalign_o
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    logic        misalign_pend_r;
    logic        misalign_pend_next_s;

    logic        id_valid_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc4_r;
    logic [31:0] id_instr_r;
    logic        id_misalign_r;

    logic        id_valid_next_s;
    logic [31:0] id_pc_next_s;
    logic [31:0] id_pc4_next_s;
    logic [31:0] id_instr_next_s;
    logic        id_misalign_next_s;

    // Address comes straight from the PC register, so stall/redirect only act after an edge.
    assign IMEM_addr_o = pc_r;
    assign pc_plus4_s  = pc_r + 32'd4;

    // Next-state selection; the if/else order encodes redirect > stall > misalign > wait > fetch.
    always_comb begin
        pc_next_s            = pc_r;
        misalign_pend_next_s = misalign_pend_r;
        id_valid_next_s      = id_valid_r;
        id_pc_next_s         = id_pc_r;
        id_pc4_next_s        = id_pc4_r;
        id_instr_next_s      = id_instr_r;
        id_misalign_next_s   = id_misalign_r;

        if (redirect_i) begin
            pc_next_s            = {redirect_pc_i[31:2], 2'b00};
            misalign_pend_next_s = |redirect_pc_i[1:0];
            id_valid_next_s      = 1'b0;
            id_instr_next_s      = NOP_INSTR;
            id_misalign_next_s   = 1'b0;
        end else if (stall_i) begin
            pc_next_s            = pc_r;
            misalign_pend_next_s = misalign_pend_r;
        end else if (misalign_pend_r) begin
            // Report the exception on the aligned PC without touching memory.
            misalign_pend_next_s = 1'b0;
            id_valid_next_s      = 1'b1;
            id_pc_next_s         = pc_r;
            id_pc4_next_s        = pc_plus4_s;
            id_instr_next_s      = NOP_INSTR;
            id_misalign_next_s   = 1'b1;
        end else if (!IMEM_ready_i) begin
            id_valid_next_s      = 1'b0;
            id_instr_next_s      = NOP_INSTR;
            id_misalign_next_s   = 1'b0;
        end else begin
            pc_next_s            = pc_plus4_s;
            id_valid_next_s      = 1'b1;
            id_pc_next_s         = pc_r;
            id_pc4_next_s        = pc_plus4_s;
            id_instr_next_s      = IMEM_data_i;
            id_misalign_next_s   = 1'b0;
        end
    end

    // PC, pending-misalign flag and IF/ID register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r            <= RESET_PC_ALIGNED;
            misalign_pend_r <= 1'b0;
            id_valid_r      <= 1'b0;
            id_pc_r         <= 32'h0000_0000;
            id_pc4_r        <= 32'h0000_0000;
            id_instr_r      <= NOP_INSTR;
            id_misalign_r   <= 1'b0;
        end else begin
            pc_r            <= pc_next_s;
            misalign_pend_r <= misalign_pend_next_s;
            id_valid_r      <= id_valid_next_s;
            id_pc_r         <= id_pc_next_s;
            id_pc4_r        <= id_pc4_next_s;
            id_instr_r      <= id_instr_next_s;
            id_misalign_r   <= id_misalign_next_s;
        end
    end

    assign if_id_valid_o    = id_valid_r;
    assign if_id_pc_o       = id_pc_r;
    assign if_id_pc4_o      = id_pc4_r;
    assign if_id_instr_o    = id_instr_r;
    assign if_id_misalign_o = id_misalign_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a small instruction-memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] IMEM_addr_o;
    logic [31:0] IMEM_data_i;
    logic        IMEM_ready_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_misalign_o;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .IMEM_addr_o      (IMEM_addr_o),
        .IMEM_data_i      (IMEM_data_i),
        .IMEM_ready_i     (IMEM_ready_i),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_id_valid_o    (if_id_valid_o),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_pc4_o      (if_id_pc4_o),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_misalign_o (if_id_misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: two fixed words at 0x0/0x4, everything else is addr ^ 0x5A000000.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem = 32'h0050_0093;
            32'h0000_0004: mem = 32'h00A0_0113;
            default:       mem = a ^ 32'h5A00_0000;
        endcase
    endfunction

    assign IMEM_data_i = mem(IMEM_addr_o);

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                                input logic [31:0] rpc, input logic ready,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_pc4,
                                input logic [31:0] e_instr, input logic e_mis);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.ready = ready;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_pc4 = e_pc4;
        v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check32(input string name, input int row, input logic [31:0] got,
                           input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL row%0d %s: got %h expected %h", row, name, got, exp);
    endtask

    initial begin
        //               rst   stl   rdr   rpc            rdy   addr           v     pc             pc4            instr          mis
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0008, 32'h00A0_0113, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0000_000C, 32'h5A00_0008, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0000_000C, 32'h5A00_0008, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0000_000C, 32'h5A00_0008, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0000_000C, 32'h5A00_0008, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0000_0010, 32'h5A00_000C, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_000C, 32'h0000_0010, NOP,           1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0000_0104, 32'h5A00_0100, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0100, 32'h0000_0104, NOP,           1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0020, 1'b0, 32'h0000_0100, 32'h0000_0104, NOP,           1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0020, 1'b0, 32'h0000_0100, 32'h0000_0104, NOP,           1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0024, 1'b1, 32'h0000_0020, 32'h0000_0024, 32'h5A00_0020, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0202, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0020, 32'h0000_0024, NOP,           1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'h0000_0204, NOP,           1'b1);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200, 32'h0000_0204, 32'h5A00_0200, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0200, 32'h0000_0204, NOP,           1'b0);
        vecs[19] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b0, 32'h0000_0200, 32'h0000_0204, NOP,           1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'h0000_0204, NOP,           1'b1);
        vecs[21] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0200, 32'h0000_0204, NOP,           1'b0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5FF_FFFC, 1'b0);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, NOP,           1'b0);
        vecs[24] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093, 1'b0);
        vecs[26] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0301, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0000, 32'h0000_0004, NOP,           1'b0);
        vecs[27] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0);
        vecs[28] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093, 1'b0);

        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'h0000_0000; IMEM_ready_i = 1'b1;

        for (int i = 0; i < 29; i++) begin
            reset         = vecs[i].rst;
            stall_i       = vecs[i].stall;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            IMEM_ready_i  = vecs[i].ready;
            @(posedge clk);
            #1;
            check32("addr",     i, IMEM_addr_o,             vecs[i].e_addr);
            check32("valid",    i, {31'd0, if_id_valid_o},    {31'd0, vecs[i].e_valid});
            check32("pc",       i, if_id_pc_o,              vecs[i].e_pc);
            check32("pc4",      i, if_id_pc4_o,             vecs[i].e_pc4);
            check32("instr",    i, if_id_instr_o,           vecs[i].e_instr);
            check32("misalign", i, {31'd0, if_id_misalign_o}, {31'd0, vecs[i].e_mis});
        end

        // Address must not react combinationally to stall/redirect before the edge.
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0800;
        #2;
        check32("addr_no_comb_path", 100, IMEM_addr_o, 32'h0000_0004);
        @(posedge clk);
        #1;
        check32("addr_after_redirect", 101, IMEM_addr_o, 32'h0000_0800);
        check32("valid_after_redirect", 101, {31'd0, if_id_valid_o}, 32'd0);

        // Stall followed by release: re-issued fetch of the redirect target.
        redirect_i = 1'b0; stall_i = 1'b1; IMEM_ready_i = 1'b0;
        @(posedge clk);
        #1;
        stall_i = 1'b0; IMEM_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check32("refetch_pc",    102, if_id_pc_o,    32'h0000_0800);
        check32("refetch_instr", 102, if_id_instr_o, 32'h5A00_0800);
        check32("refetch_addr",  102, IMEM_addr_o,   32'h0000_0804);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
